// File: rtl/fetch_queue_unit.sv
// Credit-based instruction fetch engine with a DEPTH-entry prefetch FIFO.
// Sits between instr_memory and the IF/ID register; redirects flush everything in flight.
module fetch_queue_unit #(
   parameter int unsigned    XLEN     = 32,
   parameter int unsigned    ILEN     = 32,
   parameter int unsigned    DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_redirect,
   input  logic [XLEN-1:0]            i_redirect_pc,
   input  logic                       i_stall,
   output logic                       o_imem_req,
   output logic [XLEN-1:0]            o_imem_addr,
   input  logic [ILEN-1:0]            i_imem_rdata,
   output logic                       o_valid,
   output logic [ILEN-1:0]            o_instr,
   output logic [XLEN-1:0]            o_pc,
   output logic [$clog2(DEPTH):0]     o_count,
   output logic                       o_full
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] tag_pc;
   logic            inflight;
   logic            kill;
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;
   logic [CW-1:0]   count;
   logic [ILEN-1:0] mem_instr [DEPTH];
   logic [XLEN-1:0] mem_pc    [DEPTH];

   logic            deq;
   logic            enq;
   logic [CW:0]     occ_after;
   logic [XLEN-1:0] redirect_base;

   assign redirect_base = i_redirect_pc & ~(XLEN'(3));

   assign o_valid     = (count != '0) & ~i_redirect;
   assign deq         = o_valid & ~i_stall;
   assign enq         = inflight & ~kill & ~i_redirect;

   // Occupancy counts the outstanding request, so a granted fetch always has a free slot.
   assign occ_after   = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, deq};
   assign o_imem_req  = ~i_rst & ~i_redirect & (occ_after < (CW+1)'(DEPTH));
   assign o_imem_addr = fetch_pc;

   assign o_instr     = mem_instr[rd_ptr];
   assign o_pc        = mem_pc[rd_ptr];
   assign o_count     = count;
   assign o_full      = (count == CW'(DEPTH));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         fetch_pc <= RESET_PC;
         tag_pc   <= '0;
         inflight <= 1'b0;
         kill     <= 1'b0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_instr[i] <= '0;
            mem_pc[i]    <= '0;
         end
      end else if (i_redirect) begin
         fetch_pc <= redirect_base;
         inflight <= 1'b0;
         kill     <= 1'b1;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else begin
         kill     <= 1'b0;
         inflight <= o_imem_req;
         if (o_imem_req) begin
            fetch_pc <= fetch_pc + XLEN'(4);
            tag_pc   <= fetch_pc;
         end
         if (enq) begin
            mem_instr[wr_ptr] <= i_imem_rdata;
            mem_pc[wr_ptr]    <= tag_pc;
            wr_ptr            <= wr_ptr + PW'(1);
         end
         if (deq)
            rd_ptr <= rd_ptr + PW'(1);
         case ({enq, deq})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
      !(enq && (count == CW'(DEPTH))));

endmodule
